// File: rtl/esfa_result_reporter.sv
// esfa_result_reporter: watches the ESFA harness completion flags and reports the
// verdict as an ASCII line on an 8N1 UART TX pin. It also drives sticky pass/fail LEDs.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a rising edge on didRun
//   START | start bit (low) of the current byte
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (high); then the next byte or DONE
//   DONE  | one cycle: report_done pulse, busy dropped
//
// Every output is registered, so uart_tx goes low on the cycle after the trigger edge.
// Bit periods use a down-counter that is reloaded with CLKS_PER_BIT-1 and advances at zero.
module esfa_result_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        didRun,
  input  logic        wasSuccessful,
  input  logic [31:0] address,
  output logic        uart_tx,
  output logic        busy,
  output logic        report_done,
  output logic        pass_led,
  output logic        fail_led
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t          state, stateNext;
  logic            didRunQ;
  logic            verdictQ, verdictNext;
  logic [31:0]     addrQ, addrNext;
  logic [CNT_W-1:0] clkCnt, clkCntNext;
  logic [2:0]      bitIdx, bitIdxNext;
  logic [3:0]      byteIdx, byteIdxNext;
  logic            txNext, busyNext, doneNext, passNext, failNext;
  logic            trigger;
  logic [3:0]      lastIdx;
  logic [3:0]      nibble;
  logic [7:0]      hexChar;
  logic [7:0]      msgByte;

  // Message byte for the current index, built from the latched verdict and address.
  always_comb begin
    nibble = 4'h0;
    case (byteIdx)
      4'd5:    nibble = addrQ[31:28];
      4'd6:    nibble = addrQ[27:24];
      4'd7:    nibble = addrQ[23:20];
      4'd8:    nibble = addrQ[19:16];
      4'd9:    nibble = addrQ[15:12];
      4'd10:   nibble = addrQ[11:8];
      4'd11:   nibble = addrQ[7:4];
      4'd12:   nibble = addrQ[3:0];
      default: nibble = 4'h0;
    endcase
    hexChar = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
    lastIdx = verdictQ ? 4'd5 : 4'd14;
    msgByte = 8'h00;
    if (verdictQ) begin
      case (byteIdx)
        4'd0:    msgByte = 8'h50;
        4'd1:    msgByte = 8'h41;
        4'd2:    msgByte = 8'h53;
        4'd3:    msgByte = 8'h53;
        4'd4:    msgByte = 8'h0D;
        4'd5:    msgByte = 8'h0A;
        default: msgByte = 8'h00;
      endcase
    end else begin
      case (byteIdx)
        4'd0:    msgByte = 8'h46;
        4'd1:    msgByte = 8'h41;
        4'd2:    msgByte = 8'h49;
        4'd3:    msgByte = 8'h4C;
        4'd4:    msgByte = 8'h20;
        4'd13:   msgByte = 8'h0D;
        4'd14:   msgByte = 8'h0A;
        default: msgByte = hexChar;
      endcase
    end
  end

  assign trigger = didRun & ~didRunQ & (state == IDLE);

  // Next-state and next-output logic. Defaults hold the current values.
  always_comb begin
    stateNext   = state;
    verdictNext = verdictQ;
    addrNext    = addrQ;
    clkCntNext  = clkCnt;
    bitIdxNext  = bitIdx;
    byteIdxNext = byteIdx;
    txNext      = uart_tx;
    busyNext    = busy;
    doneNext    = 1'b0;
    passNext    = pass_led;
    failNext    = fail_led;
    case (state)
      IDLE: begin
        if (trigger) begin
          stateNext   = START;
          verdictNext = wasSuccessful;
          addrNext    = address;
          byteIdxNext = 4'd0;
          bitIdxNext  = 3'd0;
          clkCntNext  = BIT_LAST;
          txNext      = 1'b0;
          busyNext    = 1'b1;
          if (wasSuccessful) passNext = 1'b1;
          else               failNext = 1'b1;
        end
      end
      START: begin
        if (clkCnt == '0) begin
          stateNext  = DATA;
          clkCntNext = BIT_LAST;
          bitIdxNext = 3'd0;
          txNext     = msgByte[0];
        end else begin
          clkCntNext = clkCnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (clkCnt == '0) begin
          clkCntNext = BIT_LAST;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            txNext     = msgByte[bitIdx + 3'd1];
          end
        end else begin
          clkCntNext = clkCnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (clkCnt == '0) begin
          if (byteIdx == lastIdx) begin
            stateNext = DONE;
            txNext    = 1'b1;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            stateNext   = START;
            byteIdxNext = byteIdx + 4'd1;
            clkCntNext  = BIT_LAST;
            txNext      = 1'b0;
          end
        end else begin
          clkCntNext = clkCnt - CNT_W'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers. reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      didRunQ     <= 1'b0;
      verdictQ    <= 1'b0;
      addrQ       <= '0;
      clkCnt      <= '0;
      bitIdx      <= '0;
      byteIdx     <= '0;
      uart_tx     <= 1'b1;
      busy        <= 1'b0;
      report_done <= 1'b0;
      pass_led    <= 1'b0;
      fail_led    <= 1'b0;
    end else begin
      state       <= stateNext;
      didRunQ     <= didRun;
      verdictQ    <= verdictNext;
      addrQ       <= addrNext;
      clkCnt      <= clkCntNext;
      bitIdx      <= bitIdxNext;
      byteIdx     <= byteIdxNext;
      uart_tx     <= txNext;
      busy        <= busyNext;
      report_done <= doneNext;
      pass_led    <= passNext;
      fail_led    <= failNext;
    end
  end

endmodule

// File: tb/tb_esfa_result_reporter.sv
// Testbench for esfa_result_reporter. A reference model builds the expected ASCII line,
// and the serial waveform is compared cycle by cycle at CLKS_PER_BIT=4.
module tb_esfa_result_reporter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        didRun = 1'b0;
  logic        wasSuccessful = 1'b0;
  logic [31:0] address = '0;
  logic        uart_tx, busy, report_done, pass_led, fail_led;

  int vectors = 0;
  int miscompares = 0;
  bit passExp = 1'b0;
  bit failExp = 1'b0;
  logic [7:0] expMsg[$];

  esfa_result_reporter #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .didRun(didRun), .wasSuccessful(wasSuccessful),
    .address(address), .uart_tx(uart_tx), .busy(busy), .report_done(report_done),
    .pass_led(pass_led), .fail_led(fail_led)
  );

  always #5 clk = ~clk;

  // Expected text of a report, from the verdict and the address.
  function automatic void buildMsg(input bit ok, input logic [31:0] a);
    string s;
    int n;
    expMsg.delete();
    if (ok) s = "PASS";
    else    s = "FAIL ";
    for (int i = 0; i < s.len(); i++) expMsg.push_back(s[i]);
    if (!ok) begin
      for (int d = 7; d >= 0; d--) begin
        n = (a >> (4 * d)) & 32'hF;
        expMsg.push_back((n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
      end
    end
    expMsg.push_back(8'd13);
    expMsg.push_back(8'd10);
  endfunction

  // Expected line level j cycles after the trigger edge, for 8N1 frames with no gaps.
  function automatic logic expTx(input int j);
    int f, b;
    logic [7:0] ch;
    f = j / (10 * CPB);
    b = (j % (10 * CPB)) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    ch = expMsg[f];
    return ch[b-1];
  endfunction

  // The next posedge must be the trigger edge. Checks the whole report and the DONE pulse.
  task automatic checkReport(input bit disturb);
    int total;
    total = expMsg.size() * 10 * CPB;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < total; j++) begin
      vectors++;
      if ({uart_tx, busy, report_done} !== {expTx(j), 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL report_wave cycle %0d: tx/busy/done got %b%b%b want %b10",
                 j, uart_tx, busy, report_done, expTx(j));
      end
      if (disturb && j == total / 3) didRun = 1'b0;
      if (disturb && j == total / 3 + 3) begin
        didRun = 1'b1;
        address = $urandom;
        wasSuccessful = ~wasSuccessful;
      end
      @(negedge clk);
    end
    vectors++;
    if ({uart_tx, busy, report_done} !== 3'b101) begin
      miscompares++;
      $display("FAIL done_cycle: tx/busy/done got %b%b%b want 101", uart_tx, busy, report_done);
    end
    @(negedge clk);
    vectors++;
    if ({uart_tx, busy, report_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL after_done: tx/busy/done got %b%b%b want 100", uart_tx, busy, report_done);
    end
    vectors++;
    if ({pass_led, fail_led} !== {passExp, failExp}) begin
      miscompares++;
      $display("FAIL leds: pass/fail got %b%b want %b%b", pass_led, fail_led, passExp, failExp);
    end
  endtask

  // Drop didRun, raise it again with the given verdict and address, then check the report.
  task automatic startReport(input bit ok, input logic [31:0] a, input bit disturb);
    @(posedge clk); #1;
    didRun = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({uart_tx, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL pre_trigger_idle: tx/busy got %b%b want 10", uart_tx, busy);
    end
    didRun = 1'b1;
    wasSuccessful = ok;
    address = a;
    buildMsg(ok, a);
    if (ok) passExp = 1'b1;
    else    failExp = 1'b1;
    checkReport(disturb);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({uart_tx, busy, report_done, pass_led, fail_led} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_values: tx/busy/done/pass/fail got %b%b%b%b%b want 10000",
               uart_tx, busy, report_done, pass_led, fail_led);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({uart_tx, busy, report_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_after_reset: tx/busy/done got %b%b%b want 100", uart_tx, busy, report_done);
    end
  endtask

  task automatic test_pass();
    startReport(1'b1, $urandom, 1'b0);
  endtask

  task automatic test_fail();
    startReport(1'b0, 32'h0000_0028, 1'b0);
  endtask

  task automatic test_hex();
    startReport(1'b0, 32'hA5F0_C3E9, 1'b0);
    startReport(1'b0, 32'hFFFF_FFF8, 1'b0);
  endtask

  task automatic test_busy_ignore();
    startReport(1'b1, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      vectors++;
      if ({uart_tx, busy, report_done} !== 3'b100) begin
        miscompares++;
        $display("FAIL held_didrun_no_retrigger cycle %0d: tx/busy/done got %b%b%b want 100",
                 k, uart_tx, busy, report_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) startReport(1'($urandom_range(0, 1)), $urandom, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    int cut;
    a = $urandom;
    cut = 3 * 10 * CPB + CPB + 10;
    @(posedge clk); #1;
    didRun = 1'b0;
    repeat (2) @(posedge clk); #1;
    didRun = 1'b1;
    wasSuccessful = 1'b0;
    address = a;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < cut; j++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    passExp = 1'b0;
    failExp = 1'b0;
    vectors++;
    if ({uart_tx, busy, report_done, pass_led, fail_led} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_mid_frame: tx/busy/done/pass/fail got %b%b%b%b%b want 10000",
               uart_tx, busy, report_done, pass_led, fail_led);
    end
    @(negedge clk);
    vectors++;
    if (report_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_done: report_done got %b want 0", report_done);
    end
    reset = 1'b1;
    buildMsg(1'b0, a);
    failExp = 1'b1;
    checkReport(1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_hex();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
